// File: rtl/run_checker_pkg.sv
// Shared types for the run checker: sweep states and NOP encodings.
package run_checker_pkg;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        SWEEP   = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [15:0] NOP_C = 16'h0001;
    localparam logic [31:0] NOP_I = 32'h00000013;

    function automatic logic is_nop(input logic [31:0] i);
        return (i[15:0] == NOP_C) || (i == NOP_I);
    endfunction

endpackage

// File: rtl/run_checker_halt_detect.sv
// Watches the fetched instruction stream and flags a halt once the core
// has repeated one instruction (or one NOP) long enough.
module halt_detect
    import run_checker_pkg::*;
#(
    parameter int STALL_LIMIT = 49,
    parameter int NOP_LIMIT   = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [31:0] inst_i,
    input  logic        inst_valid_i,
    output logic        halt_o
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam int NW = $clog2(NOP_LIMIT + 1);
    localparam logic [SW-1:0] S_LIM = SW'(STALL_LIMIT);
    localparam logic [NW-1:0] N_LIM = NW'(NOP_LIMIT);

    logic [31:0]   prev_q, prev_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [NW-1:0] nop_q, nop_d;

    always_comb begin
        prev_d  = prev_q;
        stall_d = stall_q;
        nop_d   = nop_q;
        if (clr_i) begin
            prev_d  = '0;
            stall_d = '0;
            nop_d   = '0;
        end else if (en_i && inst_valid_i) begin
            if (inst_i == prev_q) begin
                // Saturate at the limit so the halt request stays asserted
                if (stall_q != S_LIM) stall_d = stall_q + 1'b1;
                if (is_nop(inst_i) && nop_q != N_LIM) nop_d = nop_q + 1'b1;
            end else begin
                prev_d  = inst_i;
                stall_d = '0;
                nop_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q  <= '0;
            stall_q <= '0;
            nop_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            stall_q <= stall_d;
            nop_q   <= nop_d;
        end
    end

    assign halt_o = en_i && ((stall_q == S_LIM) || (nop_q == N_LIM));

endmodule

// File: rtl/run_checker.sv
// End-of-test checker: detects a halted core, then sweeps data memory
// against an answer key and reports pass/fail counts.
module run_checker
    import run_checker_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 14,
    parameter int STALL_LIMIT = 49,
    parameter int NOP_LIMIT   = 16,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [31:0]       inst,
    input  logic              inst_valid,
    input  logic              force_halt,
    input  logic              clear,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] cmp_mask,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pass_cnt,
    output logic [ADDR_W:0]   fail_cnt,
    output logic              first_fail_vld,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              all_pass
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [ADDR_W:0]   pass_q, pass_d;
    logic [ADDR_W:0]   fail_q, fail_d;
    logic              ffv_q, ffv_d;
    logic [ADDR_W-1:0] ffa_q, ffa_d;

    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] tag_q [RD_LAT];

    logic hd_halt;
    logic halt;
    logic issue;
    logic tail_vld;
    logic match;

    halt_detect #(
        .STALL_LIMIT (STALL_LIMIT),
        .NOP_LIMIT   (NOP_LIMIT)
    ) u_halt_detect (
        .clk          (clk),
        .nrst         (nrst),
        .en_i         (state_q == MONITOR),
        .clr_i        (clear),
        .inst_i       (inst),
        .inst_valid_i (inst_valid),
        .halt_o       (hd_halt)
    );

    assign halt     = (state_q == MONITOR) && (hd_halt || force_halt);
    assign issue    = (state_q == SWEEP) && !clear;
    assign tail_vld = vld_q[RD_LAT-1];
    assign match    = ((mem_rdata ^ exp_data) & mask_q) == '0;

    // Valid/address tags travel alongside the memory read latency
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            vld_q[0] <= issue;
            tag_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1] && !clear;
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ffv_d   = ffv_q;
        ffa_d   = ffa_q;
        if (clear) begin
            state_d = MONITOR;
            addr_d  = '0;
            pass_d  = '0;
            fail_d  = '0;
            ffv_d   = 1'b0;
            ffa_d   = '0;
        end else begin
            if (tail_vld) begin
                if (match) begin
                    pass_d = pass_q + 1'b1;
                end else begin
                    fail_d = fail_q + 1'b1;
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffa_d = tag_q[RD_LAT-1];
                    end
                end
            end
            unique case (state_q)
                MONITOR: begin
                    if (halt) begin
                        state_d = SWEEP;
                        addr_d  = '0;
                        last_d  = last_addr;
                        mask_d  = cmp_mask;
                    end
                end
                SWEEP: begin
                    if (addr_q == last_q) state_d = DRAIN;
                    else addr_d = addr_q + 1'b1;
                end
                DRAIN: begin
                    if (vld_q == '0) state_d = DONE;
                end
                DONE: ;
                default: state_d = MONITOR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= MONITOR;
            addr_q  <= '0;
            last_q  <= '0;
            mask_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ffv_q   <= 1'b0;
            ffa_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            ffa_q   <= ffa_d;
        end
    end

    assign mem_addr        = addr_q;
    assign busy            = (state_q == SWEEP) || (state_q == DRAIN);
    assign done            = (state_q == DONE);
    assign pass_cnt        = pass_q;
    assign fail_cnt        = fail_q;
    assign first_fail_vld  = ffv_q;
    assign first_fail_addr = ffa_q;
    assign all_pass        = done && (fail_q == '0);

endmodule

// File: tb/tb_run_checker.sv
// Bench: two checkers (read latency 1 and 3) share stimulus and are
// compared against a loop-based reference of the expected sweep results.
module tb_run_checker;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]   inst;
    logic          inst_valid;
    logic          force_halt;
    logic          clear;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] cmp_mask;

    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] rdata_a, exp_a, rdata_b, exp_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [AW:0]   pass_a, pass_b, fail_a, fail_b;
    logic          ffv_a, ffv_b, allp_a, allp_b;
    logic [AW-1:0] ffa_a, ffa_b;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] key [N];
    logic [DW-1:0] rb [3];
    logic [DW-1:0] kb [3];

    int n_pass = 0;
    int n_tot  = 0;

    run_checker #(.RD_LAT(1)) dut_a (
        .clk(clk), .nrst(nrst), .inst(inst), .inst_valid(inst_valid),
        .force_halt(force_halt), .clear(clear), .last_addr(last_addr),
        .cmp_mask(cmp_mask), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .exp_data(exp_a), .busy(busy_a), .done(done_a),
        .pass_cnt(pass_a), .fail_cnt(fail_a), .first_fail_vld(ffv_a),
        .first_fail_addr(ffa_a), .all_pass(allp_a)
    );

    run_checker #(.RD_LAT(3)) dut_b (
        .clk(clk), .nrst(nrst), .inst(inst), .inst_valid(inst_valid),
        .force_halt(force_halt), .clear(clear), .last_addr(last_addr),
        .cmp_mask(cmp_mask), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .exp_data(exp_b), .busy(busy_b), .done(done_b),
        .pass_cnt(pass_b), .fail_cnt(fail_b), .first_fail_vld(ffv_b),
        .first_fail_addr(ffa_b), .all_pass(allp_b)
    );

    always @(posedge clk) begin
        rdata_a <= mem[addr_a];
        exp_a   <= key[addr_a];
        rb[0]   <= mem[addr_b];
        kb[0]   <= key[addr_b];
        rb[1]   <= rb[0];
        kb[1]   <= kb[0];
        rb[2]   <= rb[1];
        kb[2]   <= kb[1];
    end
    assign rdata_b = rb[2];
    assign exp_b   = kb[2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < N; i++) begin
            key[i] = $urandom;
            mem[i] = key[i];
        end
    endtask

    task automatic heal_mem();
        for (int i = 0; i < N; i++) mem[i] = key[i];
    endtask

    task automatic model(input int last, input logic [31:0] mask,
                         output int p, output int f,
                         output int ffa, output bit ffv);
        p = 0; f = 0; ffa = 0; ffv = 1'b0;
        for (int i = 0; i <= last; i++) begin
            if (((mem[i] ^ key[i]) & mask) == 32'd0) p++;
            else begin
                if (!ffv) begin ffv = 1'b1; ffa = i; end
                f++;
            end
        end
    endtask

    task automatic start_force(input int last, input logic [31:0] mask);
        @(negedge clk);
        last_addr  = AW'(last);
        cmp_mask   = mask;
        force_halt = 1'b1;
        @(negedge clk);
        force_halt = 1'b0;
    endtask

    task automatic check_results(input string tag, input int last,
                                 input logic [31:0] mask);
        int p, f, ffa, cyc;
        bit ffv;
        cyc = 0;
        while (!(done_a && done_b) && cyc < last + 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done"}, {done_a, done_b}, 2'b11);
        model(last, mask, p, f, ffa, ffv);
        chk({tag, " pass_a"}, pass_a, p);
        chk({tag, " pass_b"}, pass_b, p);
        chk({tag, " fail_a"}, fail_a, f);
        chk({tag, " fail_b"}, fail_b, f);
        chk({tag, " ffv"}, {ffv_a, ffv_b}, {ffv, ffv});
        chk({tag, " ffa_a"}, ffa_a, ffa);
        chk({tag, " ffa_b"}, ffa_b, ffa);
        chk({tag, " allp"}, {allp_a, allp_b}, {2{f == 0}});
        chk({tag, " busy"}, {busy_a, busy_b}, 2'b00);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk({tag, " clr state"}, {busy_a, done_a, busy_b, done_b}, 4'b0);
        chk({tag, " clr cnt"}, {pass_a, fail_a, pass_b, fail_b}, 60'd0);
    endtask

    initial begin
        int p0, lst, k, cyc;
        logic [31:0] msk;
        inst = '0; inst_valid = 1'b0; force_halt = 1'b0; clear = 1'b0;
        last_addr = '0; cmp_mask = '0;
        fill_mem();
        repeat (3) @(negedge clk);
        chk("rst addr", {addr_a, addr_b}, 28'd0);
        chk("rst flags", {busy_a, done_a, ffv_a, allp_a,
                          busy_b, done_b, ffv_b, allp_b}, 8'd0);
        chk("rst cnt", {pass_a, fail_a, ffa_a, pass_b, fail_b}, 74'd0);
        nrst = 1'b1;

        // NOP held for 17 cycles halts on the following edge
        @(negedge clk);
        last_addr = 14'd3;
        cmp_mask = '1;
        inst = 32'h00000013;
        inst_valid = 1'b1;
        repeat (17) @(negedge clk);
        inst_valid = 1'b0;
        chk("nop17 not yet", busy_a, 1'b0);
        @(negedge clk);
        chk("nop17 halt", {busy_a, busy_b}, 2'b11);
        check_results("nop17", 3, 32'hFFFF_FFFF);
        chk("nop17 pass4", pass_a, 15'd4);

        // DONE ignores force_halt and inst
        p0 = int'(pass_a);
        force_halt = 1'b1;
        inst = 32'h1234_5678;
        inst_valid = 1'b1;
        @(negedge clk);
        force_halt = 1'b0;
        repeat (3) @(negedge clk);
        inst_valid = 1'b0;
        chk("done hold", {done_a, busy_a, pass_a, addr_a},
            {2'b10, 15'(p0), 14'd3});
        do_clear("c1");

        // Repeated non-NOP for 50 cycles halts
        inst = 32'h0000006F;
        inst_valid = 1'b1;
        repeat (50) @(negedge clk);
        inst_valid = 1'b0;
        chk("stall50 not yet", busy_a, 1'b0);
        @(negedge clk);
        chk("stall50 halt", busy_a, 1'b1);
        check_results("stall50", 3, 32'hFFFF_FFFF);
        do_clear("c2");

        // 15 NOPs broken by another inst never halt
        inst = 32'h00000013;
        inst_valid = 1'b1;
        repeat (15) @(negedge clk);
        inst = 32'h00000033;
        @(negedge clk);
        inst_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("nop15 nohalt", {busy_a, done_a}, 2'b00);

        // clear wins over force_halt in the same cycle
        clear = 1'b1;
        force_halt = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        force_halt = 1'b0;
        @(negedge clk);
        chk("clr prio", {busy_a, done_a, busy_b, done_b}, 4'b0);

        // Two corrupted words
        mem[5] = mem[5] ^ 32'h0000_0008;
        mem[9] = mem[9] ^ 32'h8000_0000;
        start_force(15, 32'hFFFF_FFFF);
        check_results("corrupt", 15, 32'hFFFF_FFFF);
        chk("corrupt lit", {fail_a, pass_a, ffa_a},
            {15'd2, 15'd14, 14'd5});
        do_clear("c3");
        heal_mem();

        // Upper-half-only mismatches hidden by mask
        mem[2] = mem[2] ^ 32'hABCD_0000;
        mem[7] = mem[7] ^ 32'h0001_0000;
        start_force(10, 32'h0000_FFFF);
        check_results("mask", 10, 32'h0000_FFFF);
        chk("mask allp", {allp_a, allp_b}, 2'b11);
        do_clear("c4");
        heal_mem();

        // clear while sweeping address 7
        mem[3] = mem[3] ^ 32'h0000_0100;
        start_force(15, 32'hFFFF_FFFF);
        cyc = 0;
        while (addr_a != 14'd7 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid addr7", addr_a, 14'd7);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid abort", {busy_a, done_a, busy_b, done_b, ffv_a, ffv_b},
            6'd0);
        chk("mid zero", {pass_a, fail_a, pass_b, fail_b, addr_a}, 74'd0);
        start_force(15, 32'hFFFF_FFFF);
        check_results("mid resweep", 15, 32'hFFFF_FFFF);
        do_clear("c5");
        heal_mem();

        // Single-word and full-range sweeps
        start_force(0, 32'hFFFF_FFFF);
        check_results("last0", 0, 32'hFFFF_FFFF);
        chk("last0 one", pass_a + fail_a, 15'd1);
        do_clear("c6");
        start_force(N - 1, 32'hFFFF_FFFF);
        check_results("full", N - 1, 32'hFFFF_FFFF);
        chk("full nowrap", {pass_a, pass_b, addr_a}, {15'(N), 15'(N), 14'(N - 1)});
        do_clear("c7");

        // Randomized sweeps
        for (int it = 0; it < 6; it++) begin
            lst = int'($urandom_range(0, 300));
            msk = (it % 2 == 0) ? 32'hFFFF_FFFF : $urandom;
            k = int'($urandom_range(0, 5));
            for (int j = 0; j < k; j++)
                mem[$urandom_range(0, lst + 5)] ^= ($urandom | 32'd1);
            start_force(lst, msk);
            check_results("rand", lst, msk);
            do_clear("crand");
            heal_mem();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/run_checker.md
RUN_CHECKER -- requirements
Module: run_checker

Interface
REQ-001 Parameter DATA_W, default 32, memory and answer-key word width.
REQ-002 Parameter ADDR_W, default 14, memory word-address width.
REQ-003 Parameter STALL_LIMIT, default 49, count of repeated identical instructions that signals halt.
REQ-004 Parameter NOP_LIMIT, default 16, count of repeated identical NOPs that signals halt.
REQ-005 Parameter RD_LAT, default 1, range 1..4, memory read latency in cycles, the same for both read ports.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 nrst  in  1  asynchronous, active-low reset.
REQ-008 inst  in  32  fetched instruction from the core IF stage.
REQ-009 inst_valid  in  1  inst is meaningful this cycle; when low, halt counters hold.
REQ-010 force_halt  in  1  single-cycle pulse that jumps straight to sweep.
REQ-011 clear  in  1  synchronous restart into MONITOR with all results zeroed.
REQ-012 last_addr  in  ADDR_W  final word address to check; sampled on entry to SWEEP.
REQ-013 cmp_mask  in  DATA_W  bit mask applied to both operands before compare; sampled on entry to SWEEP.
REQ-014 mem_addr  out  ADDR_W  read address to data memory and answer-key ROM.
REQ-015 mem_rdata  in  DATA_W  actual data, valid RD_LAT cycles after mem_addr.
REQ-016 exp_data  in  DATA_W  expected data, valid RD_LAT cycles after mem_addr.
REQ-017 busy  out  1  high in SWEEP or DRAIN.
REQ-018 done  out  1  high in DONE.
REQ-019 pass_cnt  out  ADDR_W+1  count of matching words.
REQ-020 fail_cnt  out  ADDR_W+1  count of mismatching words.
REQ-021 first_fail_vld  out  1  high once any mismatch has been captured.
REQ-022 first_fail_addr  out  ADDR_W  address of the first mismatch.
REQ-023 all_pass  out  1  high when done is high and fail_cnt is 0.

Function
REQ-024 States: MONITOR, SWEEP, DRAIN, DONE.
REQ-025 NOP definition: inst[15:0]==16'h0001 (C.NOP) or inst==32'h00000013.
REQ-026 MONITOR, inst_valid high, inst equal to the registered previous inst: stall_cnt+1; if inst is also a NOP, nop_cnt+1.
REQ-027 MONITOR, inst_valid high, inst differs from the previous inst: previous inst updated; stall_cnt and nop_cnt cleared to 0.
REQ-028 MONITOR→SWEEP in the cycle after stall_cnt==STALL_LIMIT, nop_cnt==NOP_LIMIT, or force_halt is seen; the same transition sets mem_addr=0 and latches last_addr and cmp_mask.
REQ-029 SWEEP: one address issued per cycle; mem_addr increments by 1; after issuing the latched last_addr, go to DRAIN; mem_addr never wraps.
REQ-030 Compare pipeline: an RD_LAT-deep valid/address shift register tags each issued address; at the tail, compare (mem_rdata & mask) with (exp_data & mask).
REQ-031 Compare result: match → pass_cnt+1; mismatch → fail_cnt+1; on the first mismatch only, set first_fail_vld and first_fail_addr.
REQ-032 DRAIN→DONE once the compare pipeline holds no valid entries; exactly last_addr+1 compares are performed.
REQ-033 DONE holds all results stable until clear or reset; inst is ignored in DONE.
REQ-034 clear has priority over every other event, including a halt in the same cycle; clear mid-SWEEP flushes the pipeline.
REQ-035 force_halt is ignored outside MONITOR.
REQ-036 Counter width ADDR_W+1 so a full 2^ADDR_W sweep cannot overflow.

Reset
REQ-037 On nrst low: state=MONITOR; mem_addr, counters, previous inst, pipeline valids and all outputs are 0.
REQ-038 Reset asserted mid-sweep aborts immediately with no partial-count retention.

Structure
REQ-039 A shared package holds the state enum and NOP encodings (NOP_C=16'h0001, NOP_I=32'h00000013); parameters stay local.
REQ-040 One sub-module, halt_detect, contains the inst compare, stall_cnt, nop_cnt and halt pulse; the sweep FSM and compare pipeline live in run_checker.

Verification
REQ-041 Scenario: inst=32'h00000013 held 17 cycles, last_addr=3, memory equals key, mask all-ones → done, pass_cnt=4, fail_cnt=0, all_pass=1.
REQ-042 Scenario: non-NOP inst 32'h0000006F held 50 cycles → sweep starts; a NOP run of 15 cycles broken by a different inst → no halt.
REQ-043 Scenario: words 5 and 9 corrupted, last_addr=15 → fail_cnt=2, pass_cnt=14, first_fail_addr=5.
REQ-044 Scenario: cmp_mask=32'h0000FFFF, mismatch only in bits [31:16] → all_pass=1; repeat with RD_LAT=3 → identical counts.
REQ-045 Scenario: clear asserted mid-SWEEP at address 7 → MONITOR, counts 0; the next force_halt completes a full sweep correctly.
REQ-046 Scenario: last_addr=0 → one compare; last_addr=2^ADDR_W-1 → pass_cnt=2^ADDR_W with no wrap.
